// File: rtl/shift_normalizer_8bit.sv
// Sequential normalizer: shifts a captured word one bit per cycle toward the
// selected end until the first set bit lands there. It then reports the
// normalized word and the shift count that recovers the original word.
module shift_normalizer_8bit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] shift_amt,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  // Result bus produced in SHIFT and committed to the outputs on DONE entry.
  logic             load_res;
  logic [WIDTH-1:0] res_data;
  logic [CNT_W-1:0] res_amt;
  logic             res_zero;

  // The bit that must be set for the word to count as normalized.
  logic             target_bit;
  assign target_bit = dir_q ? work_q[0] : work_q[WIDTH-1];

  // Next-state, working-register and result computation.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    load_res = 1'b0;
    res_data = '0;
    res_amt  = '0;
    res_zero = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_in;
          dir_d   = dir;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (work_q == '0) begin
          // An all-zero word never normalizes; report it immediately.
          state_d  = DONE;
          load_res = 1'b1;
          res_zero = 1'b1;
        end else if (target_bit) begin
          state_d  = DONE;
          load_res = 1'b1;
          res_data = work_q;
          res_amt  = cnt_q;
        end else begin
          // A nonzero word reaches its end within WIDTH-1 shifts, so the
          // counter cannot wrap.
          work_d = dir_q ? (work_q >> 1) : (work_q << 1);
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs; reset clears everything.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      shift_amt <= '0;
      zero      <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      if (load_res) begin
        data_out  <= res_data;
        shift_amt <= res_amt;
        zero      <= res_zero;
      end
    end
  end

endmodule

// File: doc/shift_normalizer_8bit.md
Name: shift_normalizer_8bit

Overview:
Sequential inverse of the registered 8-bit shifter. It takes a parallel word and shifts it one bit per cycle toward the chosen end until the first set bit reaches that end. It then reports the normalized word and the shift count (the shift_amt that recovers it). It sits downstream of the shifter for normalization and shift-recovery, and uses a start/busy/done handshake.

Parameters:
WIDTH, 8, data width; must be a power of two and at least 2.
CNT_W, 3, shift-count width; equals log2(WIDTH).

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset_n  input  1  synchronous active-low reset, sampled on rising edge of Clock
start  input  1  request; sampled only in IDLE
data_in  input  WIDTH  word to normalize; captured on the accepted start edge
dir  input  1  0 = normalize toward MSB (left shifts), 1 = toward LSB (right shifts); captured with data_in
busy  output  1  high while in SHIFT or DONE
done  output  1  one-cycle pulse when the result is valid
data_out  output  WIDTH  normalized word
shift_amt  output  CNT_W  number of single-bit shifts applied
zero  output  1  captured word was all zeros

Behaviour:
- One clock. Reset is synchronous and active-low. Reset_n is sampled on the rising edge of Clock; there is no asynchronous path.
- Reset (Reset_n=0 at an edge):
  - state goes to IDLE;
  - the working register and count clear;
  - busy, done, data_out, shift_amt and zero all go to 0.
  - This applies in every state. Mid-operation the result is abandoned and no done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: work<=data_in, dir_q<=dir, cnt<=0, go to SHIFT.
  - start=0 stays in IDLE.
- SHIFT (one evaluation per edge). Target bit is work[WIDTH-1] when dir_q=0, work[0] when dir_q=1.
  - If work==0: go to DONE with data_out<=0, shift_amt<=0, zero<=1.
  - Else if target bit =1: go to DONE with data_out<=work, shift_amt<=cnt, zero<=0.
  - Else: work<=work<<1 (dir_q=0) or work>>1 (dir_q=1), zero-filled; cnt<=cnt+1.
- Count bound: the nonzero case terminates after at most WIDTH-1 shifts. cnt never wraps; the maximum is 7 for WIDTH=8.
- DONE:
  - done=1 for exactly this one cycle, busy=1.
  - Next edge returns to IDLE unconditionally.
  - start seen in DONE is ignored; it is not queued.
- Latency: with n = required shift count, the start edge is k and the transition to DONE occurs at edge k+n+1. done is high during the cycle after that edge. For a zero input, n=0.
- Output holding:
  - data_out, shift_amt and zero update only on entry to DONE.
  - They hold their values through IDLE until the next DONE entry or reset.
  - They never show intermediate work/cnt values.
- start while busy (SHIFT or DONE) is ignored; data_in and dir may change freely then.
- Round-trip property:
  - dir=0: data_out >> shift_amt == captured data_in.
  - dir=1: data_out << shift_amt == captured data_in.
  - Both hold for any nonzero input.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: Reset_n=0 for 2 edges with start=1, data_in=0xFF -> busy=0, done=0, data_out=0x00, shift_amt=0, zero=0 throughout, no done afterward until a new start.
- Left normalize: data_in=0x10, dir=0, start at edge k -> done high after edge k+4, data_out=0x80, shift_amt=3, zero=0; dir=0 with data_in=0x01 -> data_out=0x80, shift_amt=7 after edge k+8.
- Right normalize: data_in=0xA0, dir=1 -> data_out=0x05, shift_amt=5, done after edge k+6; data_in=0x81, dir=1 -> shift_amt=0, data_out=0x81, done after edge k+1.
- Zero input: data_in=0x00, either dir -> done after edge k+1, zero=1, data_out=0x00, shift_amt=0; then data_in=0x40, dir=0 -> zero returns to 0, shift_amt=1.
- Handshake: start held high continuously with data_in=0x08, dir=0 -> one done pulse per IDLE visit. Changing data_in to 0x01 during SHIFT does not affect the result (shift_amt=4). Outputs stay stable between done pulses.
- Reset mid-operation: data_in=0x01, dir=0, Reset_n=0 at edge k+3 -> IDLE, all outputs 0, no done. A new start with 0x02, dir=0 yields shift_amt=6, data_out=0x80.
